// File: rtl/sonic_dist_filter.sv
// Ultrasonic distance filter: converts an echo width in microseconds to
// centimetres with a bit-serial restoring divider, rejects out-of-range
// readings, median-filters the last three good readings, and drives an
// obstacle flag with hysteresis plus a stale-sensor watchdog.
//
// Handshake: raw_valid_i is a one-cycle strobe with no ready signal. A strobe
// is accepted only while the block is idle (busy_o low); a strobe that arrives
// while busy_o is high is dropped and counted in drop_cnt_o. dist_valid_o is a
// one-cycle strobe qualifying dist_cm_o; downstream must take it immediately.
module sonic_dist_filter #(
  parameter int CNT_W       = 20,
  parameter int DIST_W      = 10,
  parameter int US_PER_CM   = 58,
  parameter int MAX_CM      = 400,
  parameter int NEAR_CM     = 20,
  parameter int CLEAR_CM    = 25,
  parameter int TIMEOUT_CYC = 25000000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [CNT_W-1:0]  raw_count_i,
  input  logic              raw_valid_i,
  output logic              busy_o,
  output logic [DIST_W-1:0] dist_cm_o,
  output logic              dist_valid_o,
  output logic              obstacle_o,
  output logic              out_of_range_o,
  output logic              stale_o,
  output logic [7:0]        drop_cnt_o,
  output logic [1:0]        state_o
);

  // Remainder is always < US_PER_CM; the shifted partial remainder needs one more bit.
  localparam int REM_W     = $clog2(US_PER_CM) + 1;
  localparam int DIV_CNT_W = $clog2(CNT_W);
  localparam int TMO_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [REM_W-1:0]     DIV_V   = REM_W'(US_PER_CM);
  localparam logic [CNT_W-1:0]     MAX_Q   = CNT_W'(MAX_CM);
  localparam logic [DIST_W-1:0]    NEAR_V  = DIST_W'(NEAR_CM);
  localparam logic [DIST_W-1:0]    CLEAR_V = DIST_W'(CLEAR_CM);
  localparam logic [TMO_W-1:0]     TMO_MAX = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [DIV_CNT_W-1:0] DIV_TOP = DIV_CNT_W'(CNT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FILT = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  state_e               state_q;
  logic [DIV_CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0]     dvd_q;
  logic [REM_W-2:0]     rem_q;
  logic [CNT_W-1:0]     quo_q;
  logic                 zero_q;
  logic [DIST_W-1:0]    h0_q, h1_q, h2_q;
  logic [1:0]           fill_q;
  logic [DIST_W-1:0]    dist_q;
  logic                 dv_q;
  logic                 obs_q;
  logic                 oor_q;
  logic                 stale_q;
  logic                 busy_q;
  logic [7:0]           drop_q, drop_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;

  logic                 capture;
  logic                 tmo_at_max;
  logic [REM_W-1:0]     rem_shift;
  logic                 rem_ge;
  logic [REM_W-2:0]     rem_next;
  logic [DIST_W-1:0]    lo01, hi01, mid_hi, med, new_dist;

  assign capture    = (state_q == S_IDLE) && raw_valid_i;
  assign tmo_at_max = (tmo_q == TMO_MAX);

  // One restoring-division step: bring down the next dividend bit and subtract if it fits.
  always_comb begin
    rem_shift = {rem_q, dvd_q[CNT_W-1]};
    rem_ge    = (rem_shift >= DIV_V);
    rem_next  = rem_ge ? (REM_W-1)'(rem_shift - DIV_V) : (REM_W-1)'(rem_shift);
  end

  // Median of three as max(min(a,b), min(max(a,b),c)); a repeated value wins ties naturally.
  always_comb begin
    lo01     = (h0_q < h1_q) ? h0_q : h1_q;
    hi01     = (h0_q < h1_q) ? h1_q : h0_q;
    mid_hi   = (hi01 < h2_q) ? hi01 : h2_q;
    med      = (lo01 > mid_hi) ? lo01 : mid_hi;
    new_dist = (fill_q == 2'd3) ? med : h0_q;
  end

  // Watchdog and drop counter next-state values; both saturate.
  always_comb begin
    tmo_d = tmo_q;
    if (capture)          tmo_d = '0;
    else if (!tmo_at_max) tmo_d = tmo_q + 1'b1;
    drop_d = drop_q;
    if ((state_q != S_IDLE) && raw_valid_i && (drop_q != 8'hFF)) drop_d = drop_q + 1'b1;
  end

  // Watchdog counter and drop counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q  <= '0;
      drop_q <= '0;
    end else begin
      tmo_q  <= tmo_d;
      drop_q <= drop_d;
    end
  end

  // Main sequencer: capture, divide, validate/filter, publish; also owns the status flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      zero_q    <= 1'b0;
      h0_q      <= '0;
      h1_q      <= '0;
      h2_q      <= '0;
      fill_q    <= '0;
      dist_q    <= '0;
      dv_q      <= 1'b0;
      obs_q     <= 1'b0;
      oor_q     <= 1'b0;
      stale_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      // Fail-safe on a silent sensor; a publish in the same cycle overrides this below.
      if (tmo_at_max) begin
        stale_q <= 1'b1;
        obs_q   <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (raw_valid_i) begin
            dvd_q     <= raw_count_i;
            zero_q    <= (raw_count_i == '0);
            rem_q     <= '0;
            quo_q     <= '0;
            div_cnt_q <= DIV_TOP;
            busy_q    <= 1'b1;
            state_q   <= S_DIV;
          end
        end
        S_DIV: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[CNT_W-2:0], rem_ge};
          dvd_q <= {dvd_q[CNT_W-2:0], 1'b0};
          if (div_cnt_q == '0) state_q <= S_FILT;
          else                 div_cnt_q <= div_cnt_q - 1'b1;
        end
        S_FILT: begin
          if (zero_q || (quo_q > MAX_Q)) begin
            oor_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            oor_q <= 1'b0;
            h2_q  <= h1_q;
            h1_q  <= h0_q;
            h0_q  <= quo_q[DIST_W-1:0];
            if (fill_q != 2'd3) fill_q <= fill_q + 1'b1;
            state_q <= S_OUT;
          end
        end
        S_OUT: begin
          dist_q  <= new_dist;
          dv_q    <= 1'b1;
          stale_q <= 1'b0;
          if (new_dist <= NEAR_V)       obs_q <= 1'b1;
          else if (new_dist >= CLEAR_V) obs_q <= 1'b0;
          else                          obs_q <= obs_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign dist_cm_o      = dist_q;
  assign dist_valid_o   = dv_q;
  assign obstacle_o     = obs_q;
  assign out_of_range_o = oor_q;
  assign stale_o        = stale_q;
  assign drop_cnt_o     = drop_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_sonic_dist_filter.sv
// Bench for sonic_dist_filter: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a transaction-level
// model of the filter.
module tb_sonic_dist_filter;

  localparam int CNT_W = 20;
  localparam int DIST_W = 10;
  localparam int T = 1000;
  localparam int LAT = 22;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CNT_W-1:0]  raw_count = '0;
  logic              raw_valid = 1'b0;
  logic              busy_o, dist_valid_o, obstacle_o, out_of_range_o, stale_o;
  logic [DIST_W-1:0] dist_cm_o;
  logic [7:0]        drop_cnt_o;
  logic [1:0]        state_o;

  sonic_dist_filter #(.TIMEOUT_CYC(T)) dut (
    .clk_i(clk), .rst_ni(rst_n), .raw_count_i(raw_count), .raw_valid_i(raw_valid),
    .busy_o(busy_o), .dist_cm_o(dist_cm_o), .dist_valid_o(dist_valid_o),
    .obstacle_o(obstacle_o), .out_of_range_o(out_of_range_o), .stale_o(stale_o),
    .drop_cnt_o(drop_cnt_o), .state_o(state_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DIST_W-1:0] exp_q[$];   // distances still to be published
  int  hist[$];                  // newest first, at most 3 good readings
  int  m_busy_left = 0;          // clocks until the current sample is finished
  bit  m_pend_ok = 0;
  int  m_since = 0;              // clocks since the last accepted sample
  int  m_drop = 0, m_dist = 0;
  bit  m_dv = 0, m_oor = 0, m_stale = 0, m_obs = 0;

  function automatic int median_of(input int q[$]);
    int s[$];
    if (q.size() < 3) return q[0];
    s = q;
    s.sort();
    return s[1];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete(); hist.delete();
      m_busy_left = 0; m_pend_ok = 0; m_since = 0; m_drop = 0; m_dist = 0;
      m_dv = 0; m_oor = 0; m_stale = 0; m_obs = 0;
    end else begin
      bit capt, out_now;
      int q;
      capt = raw_valid && (m_busy_left == 0);
      out_now = 0;
      m_dv = 0;
      if (m_busy_left > 0) begin
        if (raw_valid) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        m_busy_left--;
        if (m_pend_ok && m_busy_left == 1) m_oor = 0;
        if (m_busy_left == 0) begin
          if (m_pend_ok) begin
            m_dist = int'(exp_q.pop_front());
            m_dv = 1; m_stale = 0; out_now = 1;
            if (m_dist <= 20) m_obs = 1;
            else if (m_dist >= 25) m_obs = 0;
          end else begin
            m_oor = 1;
          end
        end
      end
      if (!out_now && m_since >= T - 1) begin
        m_stale = 1; m_obs = 1;
      end
      if (capt) begin
        q = int'(raw_count) / 58;
        m_pend_ok = (raw_count != 0) && (q <= 400);
        if (m_pend_ok) begin
          hist.push_front(q);
          if (hist.size() > 3) void'(hist.pop_back());
          exp_q.push_back(DIST_W'(median_of(hist)));
        end
        m_busy_left = m_pend_ok ? LAT : LAT - 1;
        m_since = 0;
      end else begin
        m_since++;
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    check("busy", int'(busy_o), int'(m_busy_left > 0));
    check("dist_valid", int'(dist_valid_o), int'(m_dv));
    check("dist_cm", int'(dist_cm_o), m_dist);
    check("obstacle", int'(obstacle_o), int'(m_obs));
    check("out_of_range", int'(out_of_range_o), int'(m_oor));
    check("stale", int'(stale_o), int'(m_stale));
    check("drop_cnt", int'(drop_cnt_o), m_drop);
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic pulse(input int c);
    raw_count = CNT_W'(c);
    raw_valid = 1'b1;
    @(negedge clk);
    raw_valid = 1'b0;
  endtask

  task automatic wait_dv(output int lat);
    lat = 0;
    while (lat < 40 && !dist_valid_o) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic send_valid(input int c, input int exp_d, input int exp_obs);
    int lat;
    pulse(c);
    wait_dv(lat);
    check("latency", lat, LAT);
    check("lit_dist", int'(dist_cm_o), exp_d);
    check("lit_obstacle", int'(obstacle_o), exp_obs);
    check("lit_busy_at_dv", int'(busy_o), 0);
    @(negedge clk);
    check("dv_one_cycle", int'(dist_valid_o), 0);
    check("lit_busy_after", int'(busy_o), 0);
  endtask

  task automatic send_invalid(input int c, input int exp_d);
    int seen = 0;
    pulse(c);
    repeat (LAT) begin
      @(negedge clk);
      if (dist_valid_o) seen++;
    end
    check("inv_no_dv", seen, 0);
    check("inv_oor", int'(out_of_range_o), 1);
    check("inv_dist_held", int'(dist_cm_o), exp_d);
    check("inv_busy", int'(busy_o), 0);
  endtask

  function automatic int rand_count();
    case ($urandom_range(0, 9))
      0:       return 0;
      1:       return int'($urandom_range(1, 57));
      2, 3, 4: return int'($urandom_range(58, 23257));
      5:       return int'($urandom_range(1000, 1700));
      6:       return int'($urandom_range(23200, 23320));
      7:       return int'($urandom_range(23258, 40000));
      8:       return int'($urandom_range(0, (1 << CNT_W) - 1));
      default: return int'($urandom_range(58, 3000));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int lat, seen;
    @(negedge clk);
    check("rst_busy", int'(busy_o), 0);
    check("rst_dv", int'(dist_valid_o), 0);
    check("rst_stale", int'(stale_o), 0);
    check("rst_drop", int'(drop_cnt_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // first reading: 1160 us -> 20 cm, obstacle set
    send_valid(1160, 20, 1);
    // spike rejection
    send_valid(5800, 100, 0);
    send_valid(5800, 100, 0);
    send_valid(580, 100, 0);
    // hysteresis walk
    send_valid(1160, 20, 1);
    send_valid(1334, 20, 1);
    send_valid(1450, 23, 1);
    send_valid(1450, 25, 0);
    // invalid readings leave distance alone
    send_invalid(0, 25);
    send_invalid(24000, 25);
    send_valid(580, 25, 0);
    check("oor_cleared", int'(out_of_range_o), 0);

    // watchdog: idle past the timeout
    repeat (T + 5) @(negedge clk);
    check("wd_stale", int'(stale_o), 1);
    check("wd_obstacle", int'(obstacle_o), 1);
    send_valid(2900, 25, 0);
    check("wd_stale_clr", int'(stale_o), 0);

    // back-pressure: strobes at capture+5 and capture+10 are dropped
    pulse(2900);
    repeat (4) @(negedge clk);
    raw_valid = 1'b1;
    @(negedge clk);
    raw_valid = 1'b0;
    repeat (4) @(negedge clk);
    raw_valid = 1'b1;
    @(negedge clk);
    raw_valid = 1'b0;
    wait_dv(lat);
    check("bp_latency", lat, LAT - 10);
    check("bp_dist", int'(dist_cm_o), 50);
    check("bp_drop", int'(drop_cnt_o), 2);
    @(negedge clk);

    // boundary quotients: 401 cm rejected, 400 cm accepted
    send_invalid(23258, int'(dist_cm_o));
    pulse(23257);
    wait_dv(lat);
    check("max_latency", lat, LAT);
    check("max_oor", int'(out_of_range_o), 0);
    @(negedge clk);

    // randomized traffic, with one long silence in the middle
    for (int i = 0; i < 3000; i++) begin
      raw_count = CNT_W'(rand_count());
      raw_valid = ($urandom_range(0, 99) < 12);
      @(negedge clk);
      if (i == 1500) begin
        raw_valid = 1'b0;
        repeat (T + 50) @(negedge clk);
      end
    end
    raw_valid = 1'b0;
    repeat (30) @(negedge clk);

    // continuous strobing saturates the drop counter
    for (int i = 0; i < 700; i++) begin
      raw_count = CNT_W'(rand_count());
      raw_valid = 1'b1;
      @(negedge clk);
    end
    raw_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("drop_sat", int'(drop_cnt_o), 255);

    // reset in the middle of a division abandons the sample
    pulse(5800);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_dist", int'(dist_cm_o), 0);
    check("mid_rst_obs", int'(obstacle_o), 0);
    check("mid_rst_stale", int'(stale_o), 0);
    check("mid_rst_oor", int'(out_of_range_o), 0);
    check("mid_rst_drop", int'(drop_cnt_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (dist_valid_o) seen++;
    end
    check("mid_rst_no_dv", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // hard stop if the run ever stalls
  initial begin
    #2000000;
    n_err++;
    $display("FAIL sim_timeout: got running expected finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
